mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu_pkg.sv | 39 +++
 rtl/mem_stage_lsu_load_extend.sv | 29 ++
 rtl/mem_stage_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and encodings for the M-stage load/store unit: FSM states,
// Funct3 access encodings, the load result-source code and the W-stage bundle.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size is Funct3[1:0]; bit 2 only selects zero-extension on loads.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } wb_fields_t;

  // Lane offset with the bits that would misalign the access cleared.
  function automatic logic [1:0] aligned_off(input logic [1:0] size, input logic [1:0] lo);
    if (size == SIZE_B)      return lo;
    else if (size == SIZE_H) return {lo[1], 1'b0};
    else                     return 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    o_result = i_rdata;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_BU:   o_result = {24'h0, w_byte};
      F3_HU:   o_result = {16'h0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: single-outstanding data bus master with stall, timeout
// and W-stage pipeline register. Define MISALIGN_TRAP_EN to trap misaligned h/w accesses.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
`ifdef MISALIGN_TRAP_EN
  output logic        MisalignM,
`endif
  output logic        BusErrM
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_e  r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [29:0] r_addr;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata_cap;
  logic        r_timeout;
  wb_fields_t  r_wb;

  logic        w_is_load, w_mem_op, w_start, w_misal;
  logic        w_stall, w_busy, w_timeout;
  logic [1:0]  w_size, w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;

  assign w_is_load = (ResultSrcM == RESULT_SRC_LOAD);
  assign w_mem_op  = w_is_load | MemWriteM;
  assign w_size    = Funct3M[1:0];

`ifdef MISALIGN_TRAP_EN
  assign w_misal = (r_state == ST_IDLE) & w_mem_op &
                   (((w_size == SIZE_H) & ALUResultM[0]) | (w_size[1] & (ALUResultM[1:0] != 2'b00)));
  assign w_off   = ALUResultM[1:0];
`else
  assign w_misal = 1'b0;
  assign w_off   = aligned_off(w_size, ALUResultM[1:0]);
`endif
  assign w_start = (r_state == ST_IDLE) & w_mem_op & ~w_misal;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (!w_is_load) begin
      case (w_size)
        SIZE_B: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{WriteDataM[7:0]}};
        end
        SIZE_H: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WriteDataM[15:0]}};
        end
        default: w_wdata = WriteDataM;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_busy    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) begin
        w_stall = 1'b1;
        w_next  = ST_BUSY;
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        w_busy  = 1'b1;
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          w_next = ST_DONE;
        end else if (r_cnt == CW'(MAX_WAIT - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_off       <= '0;
      r_f3        <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rdata_cap <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
          if (w_start) begin
            r_addr  <= ALUResultM[31:2];
            r_off   <= w_off;
            r_f3    <= Funct3M;
            r_we    <= MemWriteM & ~w_is_load;
            r_be    <= w_be;
            r_wdata <= w_wdata;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_rdata_cap <= w_ext;
          end else if (w_timeout) begin
            r_rdata_cap <= '0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // W register: bubble while stalled, otherwise follow M; read data only from DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb <= '0;
    end else if (w_stall) begin
      r_wb.reg_write <= 1'b0;
    end else begin
      r_wb.reg_write  <= RegWriteM & ~w_misal;
      r_wb.result_src <= ResultSrcM;
      r_wb.alu_result <= ALUResultM;
      r_wb.read_data  <= (r_state == ST_DONE) ? r_rdata_cap : 32'h0;
      r_wb.rd         <= RdM;
      r_wb.pc_plus4   <= PCPlus4M;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_misalign <= 1'b0;
    else       r_misalign <= w_misal;
  end
  assign MisalignM = r_misalign;
`endif

  load_extend u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_off),
    .i_funct3  (r_f3),
    .o_result  (w_ext)
  );

  // StallM is combinational from M in IDLE, so reset gates it to honour the all-zero reset state.
  assign StallM     = w_stall & ~reset;
  assign dmem_req   = w_busy;
  assign dmem_we    = w_busy & r_we;
  assign dmem_be    = w_busy ? r_be : 4'b0000;
  assign dmem_addr  = w_busy ? {r_addr, 2'b00} : 32'h0;
  assign dmem_wdata = w_busy ? r_wdata : 32'h0;
  assign BusErrM    = (r_state == ST_DONE) & r_timeout;

  assign RegWriteW  = r_wb.reg_write;
  assign ResultSrcW = r_wb.result_src;
  assign ALUResultW = r_wb.alu_result;
  assign ReadDataW  = r_wb.read_data;
  assign RdW        = r_wb.rd;
  assign PCPlus4W   = r_wb.pc_plus4;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed load/store vectors with hand-computed
// bus and W-stage expectations, checked by an independent negedge monitor.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int K_NOP = 0, K_LOAD = 1, K_STORE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, RegWriteW, BusErrM;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  mem_stage_lsu #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
`ifdef MISALIGN_TRAP_EN
    .MisalignM(MisalignM),
`endif
    .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
    int ack_after; bit early; bit mis;
    logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata, e_rd; int e_busy; bit e_err;
  } vec_t;

  typedef struct { logic [31:0] addr, wdata; logic [3:0] be; logic we; int req_cycles; } bus_exp_t;
  typedef struct {
    logic rw; logic [1:0] rs; logic [31:0] alu, rdata, pc4; logic [4:0] rd;
    int stall; logic err; logic mis;
  } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  vec_t     vecs[$];
  int       n_checks = 0, n_fail = 0;
  logic     in_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred with no expectation or bound expired", name);
  endtask

  function automatic vec_t mk(int kind, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int ack_after, bit early, bit mis,
                              logic [31:0] e_addr, logic [3:0] e_be, logic [31:0] e_wdata,
                              logic [31:0] e_rd, int e_busy, bit e_err);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_after = ack_after; v.early = early; v.mis = mis;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd = e_rd;
    v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic set_nop();
    RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bus_exp_t b;
    wb_exp_t  w;
    bit trap, done;
    int busy;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = v.mis;
`endif
    @(posedge clk); #1;
    RegWriteM  = (v.kind != K_STORE);
    ResultSrcM = (v.kind == K_LOAD) ? RESULT_SRC_LOAD : 2'b00;
    MemWriteM  = (v.kind == K_STORE);
    Funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    PCPlus4M   = 32'h1000 + 32'(idx * 4);
    RdM        = 5'(idx + 1);
    dmem_rdata = v.rdata;
    dmem_ack   = v.early;
    in_valid   = 1'b1;
    w.rw    = (v.kind != K_STORE) && !trap;
    w.rs    = ResultSrcM;
    w.alu   = v.addr;
    w.rdata = trap ? 32'h0 : v.e_rd;
    w.pc4   = PCPlus4M;
    w.rd    = RdM;
    w.stall = (v.kind == K_NOP || trap) ? 0 : 1 + v.e_busy;
    w.err   = v.e_err;
    w.mis   = trap;
    wb_q.push_back(w);
    if (v.kind != K_NOP && !trap) begin
      b.addr = v.e_addr; b.wdata = v.e_wdata; b.be = v.e_be;
      b.we = (v.kind == K_STORE); b.req_cycles = v.e_busy;
      bus_q.push_back(b);
    end
    busy = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (!StallM) done = 1'b1;
      else if (dmem_req) begin
        busy++;
        if (busy == v.ack_after) dmem_ack = 1'b1;
      end
    end
    if (!done) fail_now($sformatf("retire_timeout_v%0d", idx));
  endtask

  // Monitor: bus requests pop bus_q on their first cycle; each unstalled cycle pops wb_q.
  initial begin
    bus_exp_t cur_bus;
    wb_exp_t  cur_wb;
    bit       wb_pend = 1'b0, prev_req = 1'b0, bus_live = 1'b0;
    int       stall_cnt = 0, req_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wb_pend = 1'b0; prev_req = 1'b0; bus_live = 1'b0; stall_cnt = 0; req_cnt = 0;
      end else begin
        if (wb_pend) begin
          wb_pend = 1'b0;
          check("w_regwrite", 32'(RegWriteW), 32'(cur_wb.rw));
          check("w_resultsrc", 32'(ResultSrcW), 32'(cur_wb.rs));
          check("w_aluresult", ALUResultW, cur_wb.alu);
          check("w_readdata", ReadDataW, cur_wb.rdata);
          check("w_rd", 32'(RdW), 32'(cur_wb.rd));
          check("w_pcplus4", PCPlus4W, cur_wb.pc4);
`ifdef MISALIGN_TRAP_EN
          check("w_misalign", 32'(MisalignM), 32'(cur_wb.mis));
`endif
        end
        if (dmem_req && !prev_req) begin
          if (bus_q.size() == 0) fail_now("bus_unexpected_req");
          else begin
            cur_bus = bus_q.pop_front();
            bus_live = 1'b1;
            check("bus_addr", dmem_addr, cur_bus.addr);
            check("bus_be", 32'(dmem_be), 32'(cur_bus.be));
            check("bus_wdata", dmem_wdata, cur_bus.wdata);
            check("bus_we", 32'(dmem_we), 32'(cur_bus.we));
          end
          req_cnt = 0;
        end
        if (dmem_req) req_cnt++;
        if (!dmem_req && prev_req && bus_live) begin
          check("bus_req_cycles", 32'(req_cnt), 32'(cur_bus.req_cycles));
          bus_live = 1'b0;
        end
        prev_req = dmem_req;
        if (in_valid) begin
          if (StallM) begin
            if (stall_cnt > 0) check("bubble_regwrite", 32'(RegWriteW), 32'h0);
            stall_cnt++;
          end else begin
            if (wb_q.size() == 0) fail_now("wb_unexpected_retire");
            else begin
              cur_wb = wb_q.pop_front();
              check("stall_cycles", 32'(stall_cnt), 32'(cur_wb.stall));
              check("buserr", 32'(BusErrM), 32'(cur_wb.err));
              wb_pend = 1'b1;
            end
            stall_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t b;
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    set_nop();
    MemWriteM = 1'b1;
    ALUResultM = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(StallM), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_regwrite", 32'(RegWriteW), 32'h0);
    check("rst_readdata", ReadDataW, 32'h0);
    check("rst_buserr", 32'(BusErrM), 32'h0);
    set_nop();
    reset = 1'b0;

    vecs.push_back(mk(K_NOP,   F3_B,  32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_STORE, F3_W,  32'h100, 32'hDEADBEEF, 0, 2, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 2, 0));
    vecs.push_back(mk(K_STORE, F3_B,  32'h103, 32'h000000A5, 0, 1, 0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 0, 1, 0));
    vecs.push_back(mk(K_LOAD,  F3_B,  32'h102, 0, 32'h0080FF00, 1, 0, 0, 32'h100, 4'b1111, 0, 32'hFFFFFF80, 1, 0));
    vecs.push_back(mk(K_LOAD,  F3_BU, 32'h102, 0, 32'h0080FF00, 3, 1, 0, 32'h100, 4'b1111, 0, 32'h00000080, 3, 0));
    vecs.push_back(mk(K_STORE, F3_H,  32'h102, 32'h1234BEEF, 0, 1, 0, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 1, 0));
    vecs.push_back(mk(K_LOAD,  F3_H,  32'h100, 0, 32'h12348001, 1, 0, 0, 32'h100, 4'b1111, 0, 32'hFFFF8001, 1, 0));
    vecs.push_back(mk(K_LOAD,  F3_HU, 32'h102, 0, 32'h80017FFF, 1, 0, 0, 32'h100, 4'b1111, 0, 32'h00008001, 1, 0));
    vecs.push_back(mk(K_LOAD,  F3_W,  32'h104, 0, 32'hCAFEF00D, 15, 0, 0, 32'h104, 4'b1111, 0, 32'hCAFEF00D, 15, 0));
    vecs.push_back(mk(K_LOAD,  F3_W,  32'h108, 0, 32'h55555555, 0, 0, 0, 32'h108, 4'b1111, 0, 32'h0, 15, 1));
    vecs.push_back(mk(K_NOP,   F3_B,  32'hABCD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(K_LOAD,  F3_W,  32'h102, 0, 32'h11223344, 1, 0, 1, 32'h100, 4'b1111, 0, 32'h11223344, 1, 0));
    vecs.push_back(mk(K_LOAD,  F3_H,  32'h101, 0, 32'hAABBCCDD, 1, 0, 1, 32'h100, 4'b1111, 0, 32'hFFFFCCDD, 1, 0));
    vecs.push_back(mk(K_STORE, F3_H,  32'h103, 32'h55550077, 0, 1, 0, 1, 32'h100, 4'b1100, 32'h00770077, 0, 1, 0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while a load sits in BUSY, then a normal store.
    @(posedge clk); #1;
    in_valid = 1'b0;
    RegWriteM = 1'b1; ResultSrcM = RESULT_SRC_LOAD; MemWriteM = 1'b0; Funct3M = F3_W;
    ALUResultM = 32'h300; PCPlus4M = 32'h2000; RdM = 5'd7;
    b.addr = 32'h300; b.wdata = 32'h0; b.be = 4'b1111; b.we = 1'b0; b.req_cycles = 15;
    bus_q.push_back(b);
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("midrst_req", 32'(dmem_req), 32'h0);
    check("midrst_stall", 32'(StallM), 32'h0);
    check("midrst_be", 32'(dmem_be), 32'h0);
    check("midrst_regwrite", 32'(RegWriteW), 32'h0);
    check("midrst_pcplus4", PCPlus4W, 32'h0);
    check("midrst_rd", 32'(RdW), 32'h0);
    @(posedge clk); #1;
    set_nop();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("postrst_stall", 32'(StallM), 32'h0);
    check("postrst_req", 32'(dmem_req), 32'h0);
    run_vec(mk(K_STORE, F3_W, 32'h200, 32'h01020304, 0, 1, 0, 0, 32'h200, 4'b1111, 32'h01020304, 0, 1, 0), 20);

    @(posedge clk); #1;
    in_valid = 1'b0;
    set_nop();
    repeat (3) @(negedge clk);
    check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
